// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: the control/status bundle between the CPU-side register block
// and the timer sequencer.
//   master (register block): drives start/stop/clear and the config fields,
//                            and observes count/busy/paused/done.
//   slave  (timer_ctrl):     the mirror image of master.
// Optional macro TIMER_CTRL_IRQ_EN adds irq (slave->master) and irq_ack
// (master->slave).
interface timer_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
);
    logic               start;
    logic               stop;
    logic               clear;
    logic               auto_reload;
    logic [PRESC_W-1:0] prescale;
    logic [WIDTH-1:0]   preset;
    logic [WIDTH-1:0]   limit;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               paused;
    logic               done;
`ifdef TIMER_CTRL_IRQ_EN
    logic               irq;
    logic               irq_ack;
`endif

    modport master (
        output start, stop, clear, auto_reload, prescale, preset, limit,
`ifdef TIMER_CTRL_IRQ_EN
        output irq_ack,
        input  irq,
`endif
        input  count, busy, paused, done
    );

    modport slave (
        input  start, stop, clear, auto_reload, prescale, preset, limit,
`ifdef TIMER_CTRL_IRQ_EN
        input  irq_ack,
        output irq,
`endif
        output count, busy, paused, done
    );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: load/increment timer sequencer. It owns the count register,
// loads a preset on start, advances on prescaled ticks, and on reaching the
// limit either halts or reloads the preset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - timer_ctrl_if.slave (start/stop/clear, config in; count/busy/
//           paused/done out)
// Optional macro TIMER_CTRL_IRQ_EN: sticky irq, set with done and cleared by
// irq_ack. Setting wins over ack in the same cycle.
//
// state | meaning
// IDLE  | stopped, count cleared; waiting for start
// RUN   | prescaler counting, count advances on ticks
// PAUSE | count and prescaler frozen; start resumes without reload
// HALT  | terminal reached without auto-reload; count held at limit
module timer_ctrl #(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    timer_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [PRESC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic [WIDTH-1:0]   preset_q, preset_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               reload_q, reload_d;
    logic               done_q, done_d;
`ifdef TIMER_CTRL_IRQ_EN
    logic               irq_q, irq_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            psc_cnt_q <= '0;
            preset_q  <= '0;
            limit_q   <= '0;
            presc_q   <= '0;
            reload_q  <= 1'b0;
            done_q    <= 1'b0;
`ifdef TIMER_CTRL_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            preset_q  <= preset_d;
            limit_q   <= limit_d;
            presc_q   <= presc_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
`ifdef TIMER_CTRL_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        psc_cnt_d = psc_cnt_q;
        preset_d  = preset_q;
        limit_d   = limit_q;
        presc_d   = presc_q;
        reload_d  = reload_q;
        done_d    = 1'b0;

        if (bus.clear) begin
            state_d   = S_IDLE;
            count_d   = '0;
            psc_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start && !bus.stop) begin
                        preset_d  = bus.preset;
                        limit_d   = bus.limit;
                        presc_d   = bus.prescale;
                        reload_d  = bus.auto_reload;
                        count_d   = bus.preset;
                        psc_cnt_d = '0;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_d = S_PAUSE;
                    end else if (psc_cnt_q == presc_q) begin
                        // tick
                        psc_cnt_d = '0;
                        if (count_q == limit_q) begin
                            done_d = 1'b1;
                            if (reload_q) begin
                                count_d = preset_q;
                            end else begin
                                state_d = S_HALT;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        psc_cnt_d = psc_cnt_q + PRESC_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef TIMER_CTRL_IRQ_EN
    always_comb begin
        irq_d = irq_q;
        if (bus.clear) begin
            irq_d = 1'b0;
        end else if (done_d) begin
            irq_d = 1'b1;
        end else if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
    end

    assign bus.irq = irq_q;
`endif

    assign bus.count  = count_q;
    assign bus.busy   = (state_q == S_RUN);
    assign bus.paused = (state_q == S_PAUSE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl. Inputs change 1 time unit
// after a rising edge and outputs are checked at the same point, well away
// from the active edge. Expected values are hand-derived.
module tb_timer_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    timer_ctrl_if #(.WIDTH(8), .PRESC_W(4)) bus ();

    timer_ctrl #(.WIDTH(8), .PRESC_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] pre, input logic [7:0] lim,
                       input logic [3:0] psc, input logic ar);
        bus.preset      = pre;
        bus.limit       = lim;
        bus.prescale    = psc;
        bus.auto_reload = ar;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.clear = 1'b0;
`ifdef TIMER_CTRL_IRQ_EN
        bus.irq_ack = 1'b0;
`endif
        cfg(8'd0, 8'd0, 4'd0, 1'b0);

        // reset state
        #12;
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_paused", bus.paused, 0);
        chk("rst_done", bus.done, 0);
`ifdef TIMER_CTRL_IRQ_EN
        chk("rst_irq", bus.irq, 0);
`endif
        step();
        rst_n = 1'b1;
        step();

        // stop in IDLE is ignored
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("idle_stop_busy", bus.busy, 0);
        chk("idle_stop_paused", bus.paused, 0);

        // basic halt: 3,4,5,6 then done and HALT
        cfg(8'd3, 8'd6, 4'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("halt_c3", bus.count, 3);
        chk("halt_busy", bus.busy, 1);
        step(); chk("halt_c4", bus.count, 4);
        step(); chk("halt_c5", bus.count, 5);
        step(); chk("halt_c6", bus.count, 6);
        chk("halt_nodone", bus.done, 0);
        step();
        chk("halt_done", bus.done, 1);
        chk("halt_cnt_hold", bus.count, 6);
        chk("halt_busy0", bus.busy, 0);
        step();
        chk("halt_done_pulse", bus.done, 0);
        chk("halt_cnt_hold2", bus.count, 6);
        chk("halt_busy0b", bus.busy, 0);

        // prescaled auto-reload: count advances every 3 cycles, done every 9
        cfg(8'd0, 8'd2, 4'd2, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ar_c0", bus.count, 0);
        for (int k = 1; k <= 18; k++) begin
            step();
            chk($sformatf("ar_count_k%0d", k), bus.count, (k / 3) % 3);
            chk($sformatf("ar_done_k%0d", k), bus.done, (k % 9 == 0) ? 1 : 0);
            chk($sformatf("ar_busy_k%0d", k), bus.busy, 1);
        end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("ar_clear_busy", bus.busy, 0);
        chk("ar_clear_count", bus.count, 0);

        // wrap-around 254,255,0,1 then HALT
        cfg(8'd254, 8'd1, 4'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("wrap_254", bus.count, 254);
        step(); chk("wrap_255", bus.count, 255);
        step(); chk("wrap_0", bus.count, 0);
        step(); chk("wrap_1", bus.count, 1);
        chk("wrap_nodone", bus.done, 0);
        step();
        chk("wrap_done", bus.done, 1);
        chk("wrap_busy0", bus.busy, 0);
        chk("wrap_hold", bus.count, 1);

        // pause/resume with prescale=3: after k steps count=k/4, psc=k%4
        cfg(8'd0, 8'd20, 4'd3, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (22) step();
        chk("pr_pre_stop", bus.count, 5);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("pr_paused", bus.paused, 1);
        chk("pr_busy0", bus.busy, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("pr_frozen_%0d", k), bus.count, 5);
            chk($sformatf("pr_paused_%0d", k), bus.paused, 1);
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        step();
        bus.stop  = 1'b0;
        chk("pr_both_paused", bus.paused, 1);
        chk("pr_both_count", bus.count, 5);
        // resume; start stays high in RUN and must not restart
        step();
        chk("pr_resume_busy", bus.busy, 1);
        chk("pr_resume_count", bus.count, 5);
        step();
        chk("pr_psc_2to3", bus.count, 5);
        step();
        chk("pr_tick", bus.count, 6);
        bus.start = 1'b0;
        step(); step(); step();
        chk("pr_before_next", bus.count, 6);
        step();
        chk("pr_next_tick", bus.count, 7);

        // clear during RUN at count=4, then restart with new config
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        cfg(8'd4, 8'd9, 4'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("clr_c4", bus.count, 4);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("clr_count0", bus.count, 0);
        chk("clr_busy0", bus.busy, 0);
        chk("clr_done0", bus.done, 0);
        cfg(8'd10, 8'd11, 4'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cfg(8'd200, 8'd250, 4'd5, 1'b1);   // must not affect the running timer
        chk("rs_c10", bus.count, 10);
        step(); chk("rs_c11", bus.count, 11);
        step();
        chk("rs_done", bus.done, 1);
        chk("rs_busy0", bus.busy, 0);
        chk("rs_hold", bus.count, 11);

        // preset == limit, prescale 0, auto-reload: done held continuously
        cfg(8'd7, 8'd7, 4'd0, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("eq_c7", bus.count, 7);
        chk("eq_nodone", bus.done, 0);
        step(); chk("eq_done1", bus.done, 1);
        step(); chk("eq_done2", bus.done, 1);
        chk("eq_c7b", bus.count, 7);
        chk("eq_busy", bus.busy, 1);

        // async reset mid-RUN
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", bus.count, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_paused", bus.paused, 0);
        step();
        rst_n = 1'b1;
        step();

`ifdef TIMER_CTRL_IRQ_EN
        cfg(8'd0, 8'd1, 4'd0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("irq_low", bus.irq, 0);
        step();
        chk("irq_done", bus.done, 1);
        chk("irq_set", bus.irq, 1);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("irq_hold_%0d", k), bus.irq, 1);
        end
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("irq_acked", bus.irq, 0);
        cfg(8'd2, 8'd2, 4'd0, 1'b1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("irq_set2", bus.irq, 1);
        bus.irq_ack = 1'b1;
        step();
        bus.irq_ack = 1'b0;
        chk("irq_set_beats_ack", bus.irq, 1);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        chk("irq_clear", bus.irq, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
